// File: rtl/zbuf_depth_test.sv
// Z-buffer depth-test pipeline with frame clear for a 320x240 RGB444 framebuffer.
// Optional macro ZB_FORWARD_EN replaces the same-address stall with depth forwarding.
module zbuf_depth_test #(
    parameter int unsigned NUM_PIXELS = 76800,
    parameter logic [7:0]  CLEAR_Z    = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frag_valid,
    output logic        o_frag_ready,
    input  logic [16:0] i_frag_addr,
    input  logic [7:0]  i_frag_z,
    input  logic [11:0] i_frag_color,
    input  logic        i_clear,
    input  logic [11:0] i_clear_color,
    output logic        o_clear_busy,
    output logic [16:0] o_zb_raddr,
    input  logic [7:0]  i_zb_rdata,
    output logic [16:0] o_zb_waddr,
    output logic        o_zb_we,
    output logic [7:0]  o_zb_wdata,
    output logic [16:0] o_fb_addr,
    output logic        o_fb_we,
    output logic [11:0] o_fb_pixel
);

    localparam logic [1:0]  ST_RUN    = 2'd0;
    localparam logic [1:0]  ST_DRAIN  = 2'd1;
    localparam logic [1:0]  ST_CLEAR  = 2'd2;
    localparam logic [16:0] LAST_ADDR = 17'(NUM_PIXELS - 1);

    logic [1:0]  state_q,     state_d;
    logic        in_reset_q,  in_reset_d;
    logic        busy_q,      busy_d;
    logic [16:0] clr_cnt_q,   clr_cnt_d;
    logic [11:0] clr_color_q, clr_color_d;

    logic        s1_valid_q, s1_valid_d;
    logic [16:0] s1_addr_q,  s1_addr_d;
    logic [7:0]  s1_z_q,     s1_z_d;
    logic [11:0] s1_color_q, s1_color_d;
    logic        s2_valid_q, s2_valid_d;
    logic [16:0] s2_addr_q,  s2_addr_d;
    logic [7:0]  s2_z_q,     s2_z_d;
    logic [11:0] s2_color_q, s2_color_d;
    logic        s3_valid_q, s3_valid_d;
    logic [16:0] s3_addr_q,  s3_addr_d;

    // Shared write-port register: S3 of the pipeline, or the clear sweep.
    logic        wr_we_q,    wr_we_d;
    logic [16:0] wr_addr_q,  wr_addr_d;
    logic [7:0]  wr_z_q,     wr_z_d;
    logic [11:0] wr_pix_q,   wr_pix_d;

`ifdef ZB_FORWARD_EN
    logic        lw_valid_q, lw_valid_d;
    logic [16:0] lw_addr_q,  lw_addr_d;
    logic [7:0]  lw_z_q,     lw_z_d;
`endif

    logic        hazard_s;
    logic        frag_ready_s;
    logic        accept_s;
    logic [7:0]  s2_ref_z_s;
    logic        s2_pass_s;

    assign o_frag_ready = frag_ready_s;
    assign o_clear_busy = busy_q;
    assign o_zb_raddr   = s1_addr_q;
    assign o_zb_waddr   = wr_addr_q;
    assign o_zb_we      = wr_we_q;
    assign o_zb_wdata   = wr_z_q;
    assign o_fb_addr    = wr_addr_q;
    assign o_fb_we      = wr_we_q;
    assign o_fb_pixel   = wr_pix_q;

    // Next-state logic for handshake, depth pipeline, write port and clear FSM.
    always_comb begin
`ifdef ZB_FORWARD_EN
        hazard_s = 1'b0;
        if (wr_we_q && (wr_addr_q == s2_addr_q)) begin
            s2_ref_z_s = wr_z_q;
        end else if (lw_valid_q && (lw_addr_q == s2_addr_q)) begin
            s2_ref_z_s = lw_z_q;
        end else begin
            s2_ref_z_s = i_zb_rdata;
        end
        lw_valid_d = wr_we_q;
        lw_addr_d  = wr_addr_q;
        lw_z_d     = wr_z_q;
`else
        hazard_s   = (s1_valid_q && (s1_addr_q == i_frag_addr)) ||
                     (s2_valid_q && (s2_addr_q == i_frag_addr)) ||
                     (s3_valid_q && (s3_addr_q == i_frag_addr));
        s2_ref_z_s = i_zb_rdata;
`endif
        s2_pass_s    = (s2_z_q < s2_ref_z_s);
        frag_ready_s = (state_q == ST_RUN) && !busy_q && !i_clear && !hazard_s && !in_reset_q;
        accept_s     = i_frag_valid && frag_ready_s;

        in_reset_d  = 1'b0;
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;

        s1_valid_d = accept_s;
        s1_addr_d  = s1_addr_q;
        s1_z_d     = s1_z_q;
        s1_color_d = s1_color_q;
        if (accept_s) begin
            s1_addr_d  = i_frag_addr;
            s1_z_d     = i_frag_z;
            s1_color_d = i_frag_color;
        end else begin
            s1_addr_d  = s1_addr_q;
        end
        s2_valid_d = s1_valid_q;
        s2_addr_d  = s1_addr_q;
        s2_z_d     = s1_z_q;
        s2_color_d = s1_color_q;
        s3_valid_d = s2_valid_q;
        s3_addr_d  = s2_addr_q;

        wr_we_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_z_d    = wr_z_q;
        wr_pix_d  = wr_pix_q;
        if (state_q == ST_CLEAR) begin
            wr_we_d   = 1'b1;
            wr_addr_d = clr_cnt_q;
            wr_z_d    = CLEAR_Z;
            wr_pix_d  = clr_color_q;
        end else if (s2_valid_q) begin
            wr_we_d   = s2_pass_s;
            wr_addr_d = s2_addr_q;
            wr_z_d    = s2_z_q;
            wr_pix_d  = s2_color_q;
        end else begin
            wr_we_d   = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (i_clear && !busy_q) begin
                    state_d     = ST_DRAIN;
                    clr_color_d = i_clear_color;
                end else begin
                    state_d     = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q && !s3_valid_q) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = 17'd0;
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 17'd1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Busy stays up through the final clear write, which leaves CLEAR one cycle earlier.
        busy_d = (state_d != ST_RUN) || (state_q == ST_CLEAR);
    end

    // State registers with synchronous reset that aborts any clear or pipeline work.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            in_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
            clr_cnt_q   <= 17'd0;
            clr_color_q <= 12'd0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= 17'd0;
            s1_z_q      <= 8'd0;
            s1_color_q  <= 12'd0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= 17'd0;
            s2_z_q      <= 8'd0;
            s2_color_q  <= 12'd0;
            s3_valid_q  <= 1'b0;
            s3_addr_q   <= 17'd0;
            wr_we_q     <= 1'b0;
            wr_addr_q   <= 17'd0;
            wr_z_q      <= 8'd0;
            wr_pix_q    <= 12'd0;
`ifdef ZB_FORWARD_EN
            lw_valid_q  <= 1'b0;
            lw_addr_q   <= 17'd0;
            lw_z_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_reset_q  <= in_reset_d;
            busy_q      <= busy_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_z_q      <= s1_z_d;
            s1_color_q  <= s1_color_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
            s2_z_q      <= s2_z_d;
            s2_color_q  <= s2_color_d;
            s3_valid_q  <= s3_valid_d;
            s3_addr_q   <= s3_addr_d;
            wr_we_q     <= wr_we_d;
            wr_addr_q   <= wr_addr_d;
            wr_z_q      <= wr_z_d;
            wr_pix_q    <= wr_pix_d;
`ifdef ZB_FORWARD_EN
            lw_valid_q  <= lw_valid_d;
            lw_addr_q   <= lw_addr_d;
            lw_z_q      <= lw_z_d;
`endif
        end
    end

endmodule

// File: tb/tb_zbuf_depth_test.sv
// Bench for zbuf_depth_test: memory models, a per-cycle reference model and directed scenarios.
module tb_zbuf_depth_test;

    localparam int NP = 76800;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_frag_valid = 1'b0;
    logic [16:0] i_frag_addr = 17'd0;
    logic [7:0]  i_frag_z = 8'd0;
    logic [11:0] i_frag_color = 12'd0;
    logic        i_clear = 1'b0;
    logic [11:0] i_clear_color = 12'd0;
    logic        o_frag_ready, o_clear_busy, o_zb_we, o_fb_we;
    logic [16:0] o_zb_raddr, o_zb_waddr, o_fb_addr;
    logic [7:0]  zb_rdata, o_zb_wdata;
    logic [11:0] o_fb_pixel;

    always #5 clk = ~clk;

    zbuf_depth_test dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_frag_valid(i_frag_valid), .o_frag_ready(o_frag_ready),
        .i_frag_addr(i_frag_addr), .i_frag_z(i_frag_z), .i_frag_color(i_frag_color),
        .i_clear(i_clear), .i_clear_color(i_clear_color), .o_clear_busy(o_clear_busy),
        .o_zb_raddr(o_zb_raddr), .i_zb_rdata(zb_rdata),
        .o_zb_waddr(o_zb_waddr), .o_zb_we(o_zb_we), .o_zb_wdata(o_zb_wdata),
        .o_fb_addr(o_fb_addr), .o_fb_we(o_fb_we), .o_fb_pixel(o_fb_pixel)
    );

    // Read-first dual-port memories standing in for the Z-buffer and framebuffer.
    logic [7:0]  zmem  [0:NP-1];
    logic [11:0] fbmem [0:NP-1];
    always @(posedge clk) begin
        zb_rdata <= (int'(o_zb_raddr) < NP) ? zmem[o_zb_raddr] : 8'h00;
        if (o_zb_we && int'(o_zb_waddr) < NP) zmem[o_zb_waddr] <= o_zb_wdata;
        if (o_fb_we && int'(o_fb_addr) < NP) fbmem[o_fb_addr] <= o_fb_pixel;
    end

    int   cyc = 0;
    logic rst_smp = 1'b1;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= i_rst;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [16:0] addr;
        logic [7:0]  z;
        logic [11:0] col;
    } wr_t;

    wr_t         fq[$];
    logic [7:0]  ref_z [0:NP-1];
    logic        hist_v [0:2];
    logic [16:0] hist_a [0:2];
    logic        pend_v = 1'b0;
    logic [16:0] pend_a = 17'd0;
    logic        pend_clr = 1'b0;
    logic [11:0] pend_col = 12'd0;
    logic        busy_m = 1'b0;
    int          clr_rem = 0;
    int          clr_next = 0;
    logic [11:0] clr_col = 12'd0;
    logic        clr_started = 1'b0;
    int          clr_req_cyc = 0;
    int          n_wr = 0;
    int          n_clr = 0;

    // Reference model: sequential depth semantics, fixed write latency, ordered clear sweep.
    always @(negedge clk) begin
        logic exp_ready;
        logic haz;
        logic busy_now;
        if (rst_smp) begin
            for (int i = 0; i < 3; i++) hist_v[i] = 1'b0;
            pend_v = 1'b0; pend_clr = 1'b0; fq.delete();
            busy_m = 1'b0; clr_rem = 0; clr_started = 1'b0;
            chk("rst_ready", o_frag_ready, 0);
            chk("rst_busy", o_clear_busy, 0);
            chk("rst_zb_we", o_zb_we, 0);
            chk("rst_fb_we", o_fb_we, 0);
            chk("rst_raddr", o_zb_raddr, 0);
            chk("rst_waddr", o_zb_waddr, 0);
            chk("rst_wdata", o_zb_wdata, 0);
            chk("rst_fb_addr", o_fb_addr, 0);
            chk("rst_fb_pixel", o_fb_pixel, 0);
        end else begin
            hist_v[2] = hist_v[1]; hist_a[2] = hist_a[1];
            hist_v[1] = hist_v[0]; hist_a[1] = hist_a[0];
            hist_v[0] = pend_v;    hist_a[0] = pend_a;
            pend_v = 1'b0;
            if (pend_clr) begin
                pend_clr = 1'b0; busy_m = 1'b1; clr_rem = NP; clr_next = 0;
                clr_col = pend_col; clr_started = 1'b0; clr_req_cyc = cyc;
            end
            haz = 1'b0;
`ifdef ZB_FORWARD_EN
            haz = 1'b0;
`else
            for (int i = 0; i < 3; i++) if (hist_v[i] && hist_a[i] == i_frag_addr) haz = 1'b1;
`endif
            busy_now  = busy_m;
            exp_ready = !busy_m && !i_clear && !haz;
            chk("frag_ready", o_frag_ready, exp_ready);
            chk("clear_busy", o_clear_busy, busy_m);
            if (hist_v[0]) chk("zb_raddr", o_zb_raddr, hist_a[0]);
            chk("fb_we_match", o_fb_we, o_zb_we);
            if (o_zb_we) chk("fb_addr_match", o_fb_addr, o_zb_waddr);

            if (fq.size() > 0 && fq[0].due == cyc) begin
                chk("frag_we", o_zb_we, 1);
                if (o_zb_we) begin
                    n_wr++;
                    chk("frag_waddr", o_zb_waddr, fq[0].addr);
                    chk("frag_wdata", o_zb_wdata, fq[0].z);
                    chk("frag_pixel", o_fb_pixel, fq[0].col);
                end
                void'(fq.pop_front());
            end else if (o_zb_we) begin
                if (fq.size() == 0 && clr_rem > 0) begin
                    n_clr++;
                    chk("clear_addr", o_zb_waddr, clr_next);
                    chk("clear_wdata", o_zb_wdata, 8'hFF);
                    chk("clear_pixel", o_fb_pixel, clr_col);
                    clr_next++; clr_rem--; clr_started = 1'b1;
                    if (clr_rem == 0) busy_m = 1'b0;
                end else begin
                    n_wr++;
                    chk("unexpected_write", o_zb_we, 0);
                end
            end else if (clr_rem > 0 && fq.size() == 0 && (clr_started || cyc - clr_req_cyc > 16)) begin
                chk("clear_write_missing", o_zb_we, 1);
            end

            if (i_frag_valid && exp_ready) begin
                pend_v = 1'b1; pend_a = i_frag_addr;
                if (i_frag_z < ref_z[i_frag_addr]) begin
                    ref_z[i_frag_addr] = i_frag_z;
                    fq.push_back('{cyc + 3, i_frag_addr, i_frag_z, i_frag_color});
                end
            end
            if (i_clear && !busy_now) begin
                pend_clr = 1'b1; pend_col = i_clear_color;
                for (int i = 0; i < NP; i++) ref_z[i] = 8'hFF;
            end
        end
    end

    // Offers one fragment (called just after a rising edge) and returns just after its accept edge.
    task automatic send_frag(input logic [16:0] a, input logic [7:0] z, input logic [11:0] c,
                             output int stalls);
        logic acc;
        acc = 1'b0; stalls = 0;
        i_frag_valid = 1'b1; i_frag_addr = a; i_frag_z = z; i_frag_color = c;
        for (int g = 0; g < 50 && !acc; g++) begin
            @(negedge clk);
            if (o_frag_ready) acc = 1'b1;
            else stalls++;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", acc, 1);
        i_frag_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int st, st2, n0, k;
        idle(3);
        i_rst = 1'b0;
        idle(1);
        chk("ready_after_reset", o_frag_ready, 1);

        // Full-frame clear to blue.
        i_clear = 1'b1; i_clear_color = 12'h00F;
        idle(1);
        i_clear = 1'b0;
        for (k = 0; k < NP + 100 && o_clear_busy; k++) idle(1);
        chk("clear_busy_fell", o_clear_busy, 0);
        chk("clear_count", n_clr, NP);
        chk("clear_z_first", zmem[0], 8'hFF);
        chk("clear_z_last", zmem[NP-1], 8'hFF);
        chk("clear_pix_last", fbmem[NP-1], 12'h00F);

        // Single fragment, exact write timing.
        n0 = n_wr;
        send_frag(17'd100, 8'h40, 12'hF00, st);
        chk("single_stall", st, 0);
        idle(1);
        chk("single_we_early", o_zb_we, 0);
        idle(1);
        chk("single_we", o_zb_we, 1);
        chk("single_waddr", o_zb_waddr, 100);
        chk("single_wdata", o_zb_wdata, 8'h40);
        chk("single_pixel", o_fb_pixel, 12'hF00);
        idle(3);
        chk("single_mem_z", zmem[100], 8'h40);
        chk("single_mem_pix", fbmem[100], 12'hF00);
        chk("single_wr_count", n_wr - n0, 1);

        // Same address back to back: second is farther and must lose.
        n0 = n_wr;
        send_frag(17'd200, 8'h40, 12'h0AB, st);
        send_frag(17'd200, 8'h50, 12'h0CD, st2);
        chk("b2b_first_stall", st, 0);
`ifdef ZB_FORWARD_EN
        chk("b2b_second_stall", st2, 0);
`else
        chk("b2b_second_stall", st2, 3);
`endif
        idle(5);
        chk("b2b_mem_z", zmem[200], 8'h40);
        chk("b2b_mem_pix", fbmem[200], 12'h0AB);
        chk("b2b_wr_count", n_wr - n0, 1);

        // Streaming distinct addresses at full rate.
        n0 = n_wr; st2 = 0;
        for (int i = 0; i < 16; i++) begin
            send_frag(17'(i), 8'h10, 12'(i * 17), st);
            st2 += st;
        end
        chk("stream_stalls", st2, 0);
        idle(5);
        chk("stream_wr_count", n_wr - n0, 16);
        chk("stream_mem_z", zmem[15], 8'h10);

        // Equal depth fails; nearer then passes.
        n0 = n_wr;
        send_frag(17'd300, 8'h30, 12'h123, st);
        idle(5);
        chk("eq_first_count", n_wr - n0, 1);
        n0 = n_wr;
        send_frag(17'd300, 8'h30, 12'h456, st);
        idle(5);
        chk("eq_second_count", n_wr - n0, 0);
        chk("eq_mem_pix", fbmem[300], 12'h123);
        n0 = n_wr;
        send_frag(17'd300, 8'h00, 12'h789, st);
        idle(5);
        chk("nearer_count", n_wr - n0, 1);
        chk("nearer_mem_z", zmem[300], 8'h00);

        // In-flight fragment at clear, ignored second clear, reset mid-clear.
        send_frag(17'd1234, 8'h01, 12'hFFF, st);
        i_clear = 1'b1; i_clear_color = 12'h0F0;
        idle(1);
        i_clear = 1'b0;
        idle(4);
        i_clear = 1'b1; i_clear_color = 12'h0FF;
        idle(1);
        i_clear = 1'b0;
        for (k = 0; k < 3000 && !(o_zb_we && o_zb_waddr == 17'd1000); k++) idle(1);
        chk("reached_addr_1000", o_zb_waddr, 1000);
        i_rst = 1'b1;
        idle(1);
        chk("abort_zb_we", o_zb_we, 0);
        chk("abort_fb_we", o_fb_we, 0);
        chk("abort_busy", o_clear_busy, 0);
        idle(1);
        i_rst = 1'b0;
        idle(1);
        chk("abort_ready", o_frag_ready, 1);
        chk("inflight_mem_z", zmem[1234], 8'h01);
        chk("clear2_pix", fbmem[999], 12'h0F0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
